div32x32_seq: RTL and testbench
===============================

// Module: div32x32_seq
// PURPOSE
//   Sequential radix-2 restoring divider. The inverse companion of the 32x32 multiplier in the calculator datapath.
//   Accepts dividend/divisor on a start pulse and iterates one quotient bit per clock.
//   Returns quotient, remainder and a divide-by-zero flag with a one-cycle done pulse.
//   Early-out: a dividend whose upper half is zero needs only WIDTH/2 iterations.
// PARAMETERS
//   WIDTH  32  operand/result width in bits; even, >= 4
// PORTS
//   clk          in   1      clock, all state updates on rising edge
//   reset        in   1      asynchronous, active-low reset (reset==0 clears all state)
//   start        in   1      request; sampled only in IDLE
//   dividend     in   WIDTH  numerator; captured on accepted start
//   divisor      in   WIDTH  denominator; captured on accepted start
//   busy         out  1      high in every state except IDLE
//   done         out  1      one-cycle pulse; results valid from this cycle
//   quotient     out  WIDTH  registered result, held until next done
//   remainder    out  WIDTH  registered result, held until next done
//   div_by_zero  out  1      registered; set with done when divisor==0, held until next done
// BEHAVIOUR
//   Reset (async assert, sync release): state=IDLE; busy, done, div_by_zero = 0; quotient and remainder = 0.
//   States: IDLE -> LOAD -> ITER -> FINISH -> IDLE.
//   IDLE:   start==1 at edge t -> operands latched, state LOAD. busy=1 from t+1.
//   LOAD:   divisor==0 -> FINISH directly.
//           Dividend[WIDTH-1:WIDTH/2]==0 -> pre-shift the dividend by WIDTH/2 and set count=WIDTH/2.
//           Otherwise count=WIDTH. Partial remainder cleared. -> ITER.
//   ITER:   Shift {rem,dq} left 1 and trial-subtract the divisor.
//           Non-negative result -> rem=diff, q bit=1; otherwise rem kept, q bit=0.
//           Decrement count; count reaches 0 -> FINISH.
//   FINISH: Write quotient/remainder/div_by_zero registers. done=1 in the following cycle.
//   Done timing: busy drops in the same cycle that done pulses; FSM is in IDLE then and may accept a new start.
//   Latency from start edge t to done cycle:
//     full path        t+WIDTH+3 (35 for WIDTH=32)
//     short path       t+WIDTH/2+3 (19)
//     divide-by-zero   t+3
//   Arithmetic: trial subtract uses a WIDTH+1-bit difference. Borrow bit = sign.
//   Divide by zero: quotient = all ones, remainder = dividend, div_by_zero=1.
//   start while busy: ignored (no queueing, no restart). start held high across done: re-accepted in that IDLE cycle.
//   Operand inputs are don't-care except at the accepted-start edge.
//   Reset mid-operation: immediate abort to IDLE. Outputs cleared. No done pulse.
// CONFIGURATION
//   DIV_SIGNED_EN defined:
//     Operands are two's complement. Magnitudes are divided, then results are corrected in FINISH.
//     Quotient truncates toward zero. Remainder takes the dividend's sign.
//     Short path tests the upper half of |dividend|.
//     Overflow case (most negative value / -1): quotient = most negative value, remainder 0, div_by_zero=0.
//     Divide by zero gives the same result as the unsigned case. Latency unchanged.
//   DIV_SIGNED_EN undefined: unsigned only. No sign logic synthesised.
// TESTING
//   1. 100 / 7 (short path)
//        -> quotient=14, remainder=2, div_by_zero=0; done exactly 19 cycles after start; busy=1 between.
//   2. 0xFFFF_FFFF / 0x10 (full path)
//        -> quotient=0x0FFF_FFFF, remainder=0xF; done 35 cycles after start.
//   3. 0x1234 / 0
//        -> quotient=0xFFFF_FFFF, remainder=0x1234, div_by_zero=1; done 3 cycles after start.
//   4. start pulsed again while busy, then reset=0 for 1 cycle at iteration 10
//        -> extra start ignored; on reset busy=0, done never pulses, outputs 0.
//        Next 9/3 -> quotient=3, remainder=0.
//   5. (DIV_SIGNED_EN) -7 / 2 -> quotient=0xFFFF_FFFD, remainder=0xFFFF_FFFF.
//      0x8000_0000 / 0xFFFF_FFFF -> quotient=0x8000_0000, remainder=0.
//   6. Back-to-back with start held high: 50/5 then 1000/10
//        -> two done pulses, 19 cycles apart. Results 10 r 0, then 100 r 0.

Source files
------------

// File: rtl/div32x32_seq_if.sv
// div32x32_seq_if
//   Handshake/operand bundle for the sequential divider.
//   master : requester side (drives start and operands, observes results)
//   slave  : divider side
// Signals
//   start        request pulse, sampled only while the divider is idle
//   dividend     numerator, captured on the accepted start edge
//   divisor      denominator, captured on the accepted start edge
//   busy         high whenever the divider is not idle
//   done         one-cycle pulse, results valid from this cycle
//   quotient     registered result, held until the next done
//   remainder    registered result, held until the next done
//   div_by_zero  registered flag, set with done when divisor was zero
interface div32x32_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div32x32_seq.sv
// div32x32_seq
//   Sequential radix-2 restoring divider, one quotient bit per clock.
//   IDLE -> LOAD -> ITER -> FINISH -> IDLE. A dividend whose upper half is
//   zero is pre-shifted so only WIDTH/2 iterations run. Divide by zero skips
//   ITER and returns quotient=all ones, remainder=dividend, div_by_zero=1.
// Ports
//   clk    rising-edge clock
//   reset  asynchronous active-low reset, clears all state and outputs
//   bus    div32x32_seq_if.slave (start/operands in, busy/done/results out)
// Configuration
//   DIV_SIGNED_EN : when defined, operands are two's complement; magnitudes
//                   are divided and the signs fixed up in FINISH (quotient
//                   truncates toward zero, remainder follows the dividend).
//                   When undefined the divider is unsigned only.
module div32x32_seq #(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           reset,
  div32x32_seq_if.slave bus
);

  localparam int HALF = WIDTH / 2;
  localparam int CW   = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ITER   = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t           state, state_nxt;

  logic [WIDTH-1:0] a_q;      // dividend as captured (raw)
  logic [WIDTH-1:0] b_q;      // divisor: raw until LOAD, magnitude afterwards
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] dq;       // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] rem;      // partial remainder
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] fin_q;
  logic [WIDTH-1:0] fin_r;

  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] rem_r;
  logic             dbz_r;
  logic             done_r;

`ifdef DIV_SIGNED_EN
  logic             neg_q;
  logic             neg_r;

  function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v);
    if (v < 0) return -v;
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic signed [WIDTH-1:0] v,
                                                input logic                   en);
    if (en) return -v;
    return v;
  endfunction
`endif

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = LOAD;
      LOAD:    state_nxt = (b_q == '0) ? FINISH : ITER;
      ITER:    if (cnt == CW'(1)) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand magnitudes; unsigned build passes operands straight through
  always_comb begin
`ifdef DIV_SIGNED_EN
    mag_a = abs_val(a_q);
    mag_b = abs_val(b_q);
`else
    mag_a = a_q;
    mag_b = b_q;
`endif
  end

  // Trial subtraction: the WIDTH+1-bit difference's top bit is the borrow
  always_comb begin
    shifted = {rem, dq[WIDTH-1]};
    diff    = shifted - {1'b0, b_q};
  end

  // Result selection and sign correction for FINISH
  always_comb begin
    if (b_q == '0) begin
      fin_q = '1;
      fin_r = a_q;
    end else begin
`ifdef DIV_SIGNED_EN
      fin_q = cond_neg(dq, neg_q);
      fin_r = cond_neg(rem, neg_r);
`else
      fin_q = dq;
      fin_r = rem;
`endif
    end
  end

  // Iteration datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q <= '0;
      b_q <= '0;
      dq  <= '0;
      rem <= '0;
      cnt <= '0;
`ifdef DIV_SIGNED_EN
      neg_q <= 1'b0;
      neg_r <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            a_q <= bus.dividend;
            b_q <= bus.divisor;
          end
        end
        LOAD: begin
          rem <= '0;
          b_q <= mag_b;
`ifdef DIV_SIGNED_EN
          neg_q <= a_q[WIDTH-1] ^ b_q[WIDTH-1];
          neg_r <= a_q[WIDTH-1];
`endif
          // Upper half zero: leading quotient bits are known to be zero
          if (mag_a[WIDTH-1:HALF] == '0) begin
            dq  <= mag_a << HALF;
            cnt <= CW'(HALF);
          end else begin
            dq  <= mag_a;
            cnt <= CW'(WIDTH);
          end
        end
        ITER: begin
          dq  <= {dq[WIDTH-2:0], ~diff[WIDTH]};
          rem <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
          cnt <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Result registers and done pulse (done lands while the FSM is back in IDLE)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      quo_r  <= '0;
      rem_r  <= '0;
      dbz_r  <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= (state == FINISH);
      if (state == FINISH) begin
        quo_r <= fin_q;
        rem_r <= fin_r;
        dbz_r <= (b_q == '0);
      end
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_r;
  assign bus.quotient    = quo_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_div32x32_seq.sv
// tb_div32x32_seq
//   Testbench for div32x32_seq: a table of operand/result/latency records is
//   applied in a loop, expected results are queued when each start is
//   accepted and compared when done pulses. Hand-written sequences cover the
//   abort-by-reset and back-to-back-start cases.
module tb_div32x32_seq;
  localparam int W = 32;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  div32x32_seq_if #(.WIDTH(W)) bus ();

  div32x32_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
  } vec_t;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
    int           t0;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[10];

  int n_tests   = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int n_done    = 0;
  int last_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, req);
    end
  endtask

  // Scoreboard monitor: sample one time unit after each rising edge
  always @(posedge clk) begin : mon
    exp_t e;
    #1;
    if (reset) begin
      if (bus.done) begin
        n_done++;
        last_done = cyc;
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: done=1 at cycle %0d, want 0", cyc);
        end else begin
          e = sb.pop_front();
          chk("quotient",    bus.quotient,        e.q);
          chk("remainder",   bus.remainder,       e.r);
          chk("div_by_zero", W'(bus.div_by_zero), W'(e.dz));
          chk("latency",     W'(cyc - e.t0 + 1),  W'(e.lat));
          chk("busy_at_done", W'(bus.busy),       '0);
        end
      end else if (sb.size() != 0 && cyc > sb[0].t0) begin
        chk("busy_high", W'(bus.busy), W'(1));
      end
    end
  end

  task automatic push_exp(input logic [W-1:0] q, input logic [W-1:0] r,
                          input logic dz, input int lat, input int t0);
    exp_t e;
    e.q   = q;
    e.r   = r;
    e.dz  = dz;
    e.lat = lat;
    e.t0  = t0;
    sb.push_back(e);
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] q, input logic [W-1:0] r,
                          input logic dz, input int lat, output int t0);
    @(negedge clk);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
    t0 = cyc;
    push_exp(q, r, dz, lat, t0);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #2;
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout_%s: %0d results outstanding, want 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int nd;
    int d1;

`ifdef DIV_SIGNED_EN
    tbl[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 19};
    tbl[1] = '{32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 19};
    tbl[2] = '{32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'h0,          1'b0, 35};
    tbl[3] = '{32'h1234,       32'h0,          32'hFFFF_FFFF,  32'h1234,       1'b1, 3};
    tbl[4] = '{32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 19};
    tbl[5] = '{32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0, 19};
    tbl[6] = '{32'h8000_0000,  32'd2,          32'hC000_0000,  32'h0,          1'b0, 35};
    tbl[7] = '{32'hFFFF_0000,  32'd3,          32'hFFFF_AAAB,  32'hFFFF_FFFF,  1'b0, 35};
    tbl[8] = '{32'h7FFF_FFFF,  32'h10,         32'h07FF_FFFF,  32'hF,          1'b0, 35};
    tbl[9] = '{32'hFFFF_FFFF,  32'h0,          32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 3};
`else
    tbl[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 19};
    tbl[1] = '{32'hFFFF_FFFF,  32'h10,         32'h0FFF_FFFF,  32'hF,          1'b0, 35};
    tbl[2] = '{32'h1234,       32'h0,          32'hFFFF_FFFF,  32'h1234,       1'b1, 3};
    tbl[3] = '{32'd9,          32'd3,          32'd3,          32'd0,          1'b0, 19};
    tbl[4] = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0, 19};
    tbl[5] = '{32'h0000_FFFF,  32'd1,          32'h0000_FFFF,  32'd0,          1'b0, 19};
    tbl[6] = '{32'h0001_0000,  32'd3,          32'h0000_5555,  32'd1,          1'b0, 35};
    tbl[7] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 35};
    tbl[8] = '{32'd5,          32'hFFFF_FFFF,  32'd0,          32'd5,          1'b0, 19};
    tbl[9] = '{32'h8000_0000,  32'h0,          32'hFFFF_FFFF,  32'h8000_0000,  1'b1, 3};
`endif

    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",        W'(bus.busy),        '0);
    chk("rst_done",        W'(bus.done),        '0);
    chk("rst_quotient",    bus.quotient,        '0);
    chk("rst_remainder",   bus.remainder,       '0);
    chk("rst_div_by_zero", W'(bus.div_by_zero), '0);
    @(negedge clk);
    reset = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      start_op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].lat, t0);
      wait_drain($sformatf("vec%0d", i));
    end

    // Extra start while busy, then reset during iteration 10
    nd = n_done;
    start_op(32'hFFFF_0000, 32'd3, '0, '0, 1'b0, 35, t0);
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int i = 0; i < 20 && cyc != t0 + 11; i++) begin
      @(posedge clk);
      #1;
    end
    chk("busy_before_abort", W'(bus.busy), W'(1));
    #1;
    reset = 1'b0;
    sb.delete();
    #1;
    chk("abort_busy",      W'(bus.busy),        '0);
    chk("abort_done",      W'(bus.done),        '0);
    chk("abort_quotient",  bus.quotient,        '0);
    chk("abort_remainder", bus.remainder,       '0);
    chk("abort_dbz",       W'(bus.div_by_zero), '0);
    @(negedge clk);
    reset = 1'b1;
    repeat (45) @(posedge clk);
    #2;
    chk("no_done_after_abort", W'(n_done), W'(nd));
    chk("idle_after_abort",    W'(bus.busy), '0);
    chk("held_quotient",       bus.quotient, '0);
    start_op(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 19, t0);
    wait_drain("after_abort");

    // Back-to-back with start held high across done
    nd = n_done;
    @(negedge clk);
    bus.dividend = 32'd50;
    bus.divisor  = 32'd5;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    push_exp(32'd10, 32'd0, 1'b0, 19, cyc);
    bus.dividend = 32'd1000;
    bus.divisor  = 32'd10;
    for (int i = 0; i < 40 && n_done == nd; i++) begin
      @(posedge clk);
      #2;
    end
    d1 = last_done;
    if (n_done == nd) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout_b2b_first: no done seen, want done");
      sb.delete();
      bus.start = 1'b0;
    end else begin
      push_exp(32'd100, 32'd0, 1'b0, 19, d1 + 1);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_drain("b2b_second");
      chk("b2b_gap",   W'(last_done - d1), W'(19));
      chk("b2b_count", W'(n_done - nd),    W'(2));
    end

    repeat (5) @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
